// File: rtl/oam_dma_pkg.sv
// Shared types and constants for the OAM DMA bus arbiter.
package oam_dma_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        READ,
        WRITE
    } dma_state_t;

    typedef enum logic [1:0] {
        SEL_MAIN,
        SEL_HRAM,
        SEL_DMA_REG
    } addr_sel_t;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam int          DMA_LEN      = 160;
    localparam logic [7:0]  LAST_IDX     = 8'(DMA_LEN - 1);
    localparam logic [15:0] HRAM_LO      = 16'hFF80;
    localparam logic [15:0] HRAM_HI      = 16'hFFFE;
    localparam logic [7:0]  ECHO_HI      = 8'hE0;

    // Sources at E0xx and above read through the echo-RAM mirror.
    function automatic logic [7:0] echo_fold(input logic [7:0] hi);
        return (hi < ECHO_HI) ? hi : hi - 8'h20;
    endfunction

endpackage

// File: rtl/oam_dma_arbiter_decode.sv
// Combinational classification of a CPU address into HRAM,
// the DMA source register, or the main bus.
module oam_dma_decode
    import oam_dma_pkg::*;
(
    input  logic [15:0] addr,
    output addr_sel_t   sel
);

    always_comb begin
        sel = SEL_MAIN;
        unique case (1'b1)
            (addr >= HRAM_LO && addr <= HRAM_HI): sel = SEL_HRAM;
            (addr == DMA_REG_ADDR):               sel = SEL_DMA_REG;
            default:                              sel = SEL_MAIN;
        endcase
    end

endmodule

// File: rtl/oam_dma_arbiter.sv
// SM83 bus arbiter with OAM DMA engine at FF46.
// Optional: OAM_DMA_RESTART_EN lets an FF46 write restart a running copy.
module oam_dma_arbiter
    import oam_dma_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_d_out,
    input  logic        cpu_write,
    output logic [7:0]  cpu_d_in,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_d_out,
    output logic        mem_write,
    input  logic [7:0]  mem_d_in,
    output logic [6:0]  hram_addr,
    output logic [7:0]  hram_d_out,
    output logic        hram_write,
    input  logic [7:0]  hram_d_in,
    output logic        busy
);

    dma_state_t state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] dma_reg_q, dma_reg_d;
    logic [7:0] data_q, data_d;
    logic [7:0] src_hi_q, src_hi_d;
    addr_sel_t  sel;
    logic       dma_wr;
    logic       start;

    oam_dma_decode u_decode (
        .addr (cpu_addr),
        .sel  (sel)
    );

    assign dma_wr = cpu_write && (sel == SEL_DMA_REG);

`ifdef OAM_DMA_RESTART_EN
    assign start = dma_wr;
`else
    assign start = dma_wr && (state_q == IDLE);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            idx_q     <= 8'h00;
            dma_reg_q <= 8'hFF;
            data_q    <= 8'h00;
            src_hi_q  <= 8'h00;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            dma_reg_q <= dma_reg_d;
            data_q    <= data_d;
            src_hi_q  <= src_hi_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        src_hi_d  = src_hi_q;
        dma_reg_d = dma_wr ? cpu_d_out : dma_reg_q;
        unique case (state_q)
            SETUP: state_d = READ;
            READ: begin
                data_d  = mem_d_in;
                state_d = WRITE;
            end
            WRITE: begin
                if (idx_q == LAST_IDX) begin
                    idx_d   = 8'h00;
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 8'h01;
                    state_d = READ;
                end
            end
            default: ;
        endcase
        // Source page is frozen here; later FF46 writes only change readback.
        if (start) begin
            state_d  = SETUP;
            idx_d    = 8'h00;
            src_hi_d = echo_fold(cpu_d_out);
        end
    end

    always_comb begin
        mem_addr   = 16'h0000;
        mem_d_out  = cpu_d_out;
        mem_write  = 1'b0;
        hram_addr  = cpu_addr[6:0];
        hram_d_out = cpu_d_out;
        hram_write = 1'b0;
        cpu_d_in   = 8'hFF;
        unique case (sel)
            SEL_HRAM: begin
                hram_write = cpu_write;
                cpu_d_in   = hram_d_in;
            end
            SEL_DMA_REG: cpu_d_in = dma_reg_q;
            default: begin
                if (state_q == IDLE) begin
                    mem_write = cpu_write;
                    cpu_d_in  = mem_d_in;
                end
            end
        endcase
        unique case (state_q)
            IDLE:  mem_addr = cpu_addr;
            SETUP: mem_addr = 16'h0000;
            READ:  mem_addr = {src_hi_q, idx_q};
            WRITE: begin
                mem_addr  = OAM_BASE + {8'h00, idx_q};
                mem_d_out = data_q;
                mem_write = 1'b1;
            end
            default: mem_addr = 16'h0000;
        endcase
        if (!rst) begin
            mem_addr   = 16'h0000;
            mem_write  = 1'b0;
            hram_write = 1'b0;
        end
    end

    assign busy = rst && (state_q != IDLE);

endmodule
